// File: rtl/xras_settlement_serializer.sv
// Packet FIFO plus beat serializer: buffers wide settlement packets and streams
// them as BEAT_W beats on a valid/ready link, each packet followed by a checksum/sequence trailer.
module xras_settlement_serializer #(
    parameter int PKT_W      = 4096,
    parameter int BEAT_W     = 128,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [PKT_W-1:0]                  settlement_packet,
    input  logic                              packet_valid,
    output logic [BEAT_W-1:0]                 tx_data,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    output logic                              tx_first,
    output logic                              tx_last,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              busy,
    output logic [15:0]                       drop_count,
    output logic [15:0]                       sent_count
);

    localparam int NB    = PKT_W / BEAT_W;
    localparam int WPB   = BEAT_W / 32;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, DATA, TRAILER} state_t;

    state_t             state, state_next;
    logic [PKT_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [PKT_W-1:0]   shreg;
    logic [IDX_W-1:0]   beat_idx;
    logic [31:0]        checksum;
    logic [31:0]        beat_xor;
    logic [15:0]        seq;
    logic               pop, push, fifo_empty, fifo_full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    // A full FIFO still accepts a packet when the head leaves in the same cycle.
    assign push       = packet_valid && (!fifo_full || pop);
    assign fifo_count = count;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_valid   = 1'b0;
        tx_first   = 1'b0;
        tx_last    = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_first = (beat_idx == '0);
                if (tx_ready && beat_idx == IDX_W'(NB - 1)) begin
                    state_next = TRAILER;
                end
            end
            TRAILER: begin
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                if (tx_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_data = '0;
        if (state == DATA) begin
            tx_data = shreg[BEAT_W-1:0];
        end else if (state == TRAILER) begin
            tx_data[31:0]  = checksum;
            tx_data[47:32] = seq;
        end
    end

    always_comb begin
        beat_xor = '0;
        for (int unsigned w = 0; w < WPB; w++) begin
            beat_xor = beat_xor ^ shreg[w*32 +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= settlement_packet;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            beat_idx   <= '0;
            checksum   <= '0;
            seq        <= '0;
            sent_count <= '0;
            drop_count <= '0;
        end else begin
            if (state == DATA && tx_ready) begin
                shreg    <= shreg >> BEAT_W;
                beat_idx <= beat_idx + IDX_W'(1);
                checksum <= checksum ^ beat_xor;
            end
            if (state == TRAILER && tx_ready) begin
                seq        <= seq + 16'd1;
                sent_count <= sent_count + 16'd1;
            end
            if (pop) begin
                shreg    <= mem[rd_ptr];
                beat_idx <= '0;
                checksum <= '0;
            end
            if (packet_valid && !push && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_xras_settlement_serializer.sv
// Directed bench for xras_settlement_serializer: table-driven packets plus
// overflow, simultaneous push/pop and mid-packet reset sequences.
module tb_xras_settlement_serializer;

    localparam int PKT_W      = 4096;
    localparam int BEAT_W     = 128;
    localparam int FIFO_DEPTH = 2;
    localparam int NB         = PKT_W / BEAT_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [PKT_W-1:0]   settlement_packet;
    logic               packet_valid;
    logic [BEAT_W-1:0]  tx_data;
    logic               tx_valid;
    logic               tx_ready = 1'b0;
    logic               tx_first;
    logic               tx_last;
    logic [1:0]         fifo_count;
    logic               busy;
    logic [15:0]        drop_count;
    logic [15:0]        sent_count;

    xras_settlement_serializer #(
        .PKT_W      (PKT_W),
        .BEAT_W     (BEAT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .settlement_packet (settlement_packet),
        .packet_valid      (packet_valid),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .tx_first          (tx_first),
        .tx_last           (tx_last),
        .fifo_count        (fifo_count),
        .busy              (busy),
        .drop_count        (drop_count),
        .sent_count        (sent_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [BEAT_W-1:0] d;
        logic              f;
        logic              l;
        int unsigned       cyc;
    } beat_t;

    typedef struct {
        logic [PKT_W-1:0] pkt;
        logic [31:0]      csum;
        logic [15:0]      seq;
        int               mode;
    } vec_t;

    beat_t       q[$];
    int unsigned cyc = 0;
    int          mode = 0;
    int unsigned phase = 0;
    int unsigned last_trailer_cyc = 0;

    always @(posedge clk) cyc++;

    // mode 0: always ready, 1: ready pattern 1,0,0,1 repeating, 2: never ready
    always @(posedge clk) begin
        #1;
        case (mode)
            0: tx_ready = 1'b1;
            1: begin
                tx_ready = (phase % 4 == 0) || (phase % 4 == 3);
                phase++;
            end
            default: tx_ready = 1'b0;
        endcase
    end

    logic              prev_stall = 1'b0;
    logic [BEAT_W-1:0] prev_d;
    logic              prev_f, prev_l;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, prev_d);
                chk("hold_flags", {tx_first, tx_last}, {prev_f, prev_l});
            end
            if (tx_valid) chk("first_last_excl", tx_first && tx_last, 0);
            if (tx_valid && tx_ready) q.push_back('{tx_data, tx_first, tx_last, cyc});
            prev_stall = tx_valid && !tx_ready;
            prev_d     = tx_data;
            prev_f     = tx_first;
            prev_l     = tx_last;
        end
    end

    task automatic send_pkt(input logic [PKT_W-1:0] p);
        @(posedge clk); #1;
        settlement_packet = p;
        packet_valid      = 1'b1;
        @(posedge clk); #1;
        packet_valid      = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        for (int t = 0; t < 4000 && q.size() < n; t++) @(posedge clk);
        #1;
        chk("beat_timeout", q.size() >= n, 1);
    endtask

    task automatic check_pkt(input logic [PKT_W-1:0] pkt, input logic [31:0] csum,
                             input logic [15:0] s, input logic b2b, input string nm);
        beat_t b;
        if (q.size() < NB + 1) begin
            chk({nm, "/beats_avail"}, q.size(), NB + 1);
            q.delete();
            return;
        end
        for (int k = 0; k < NB; k++) begin
            b = q.pop_front();
            chk({nm, "/data"}, b.d, pkt[k*BEAT_W +: BEAT_W]);
            chk({nm, "/data_flags"}, {b.f, b.l}, {(k == 0), 1'b0});
            if (k == 0 && b2b) chk({nm, "/no_bubble"}, b.cyc, last_trailer_cyc + 1);
        end
        b = q.pop_front();
        chk({nm, "/trl_csum"}, b.d[31:0], csum);
        chk({nm, "/trl_seq"}, b.d[47:32], s);
        chk({nm, "/trl_upper"}, b.d[BEAT_W-1:48], 0);
        chk({nm, "/trl_flags"}, {b.f, b.l}, 2'b01);
        last_trailer_cyc = b.cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout reached");
        $fatal(1);
    end

    vec_t             vecs[4];
    logic [PKT_W-1:0] ovf[5];
    logic [PKT_W-1:0] pf, pg;

    initial begin
        for (int i = 0; i < 4; i++) vecs[i].pkt = '0;
        for (int w = 0; w < 128; w++) vecs[0].pkt[w*32 +: 32] = w;
        vecs[0].csum = 32'h0;        vecs[0].seq = 16'd0; vecs[0].mode = 0;
        vecs[1].pkt[5*32 +: 32] = 32'hDEADBEEF;
        vecs[1].csum = 32'hDEADBEEF; vecs[1].seq = 16'd1; vecs[1].mode = 0;
        vecs[2].pkt[31:0] = 32'h12345678;
        vecs[2].pkt[127*32 +: 32] = 32'h0F0F0F0F;
        vecs[2].csum = 32'h1D3B5977; vecs[2].seq = 16'd2; vecs[2].mode = 1;
        vecs[3].pkt = '1;
        vecs[3].csum = 32'h0;        vecs[3].seq = 16'd3; vecs[3].mode = 1;
        for (int j = 0; j < 5; j++) begin
            ovf[j] = '0;
            ovf[j][31:0] = j + 1;
        end
        pf = '0; pf[31:0] = 32'h9;
        pg = '0; pg[31:0] = 32'hA5;

        rst_n = 1'b0;
        packet_valid = 1'b0;
        settlement_packet = '0;
        #12;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_first", tx_first, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_sent", sent_count, 0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            mode = vecs[i].mode;
            send_pkt(vecs[i].pkt);
            if (i == 0) begin
                chk("lat_fifo_count1", fifo_count, 1);
                chk("lat_valid_low", tx_valid, 0);
                @(posedge clk); #1;
                chk("lat_valid_high", tx_valid, 1);
                chk("lat_first", tx_first, 1);
                chk("lat_beat0", tx_data, {32'd3, 32'd2, 32'd1, 32'd0});
                chk("lat_fifo_count0", fifo_count, 0);
                chk("lat_busy", busy, 1);
            end
            wait_beats(NB + 1);
            check_pkt(vecs[i].pkt, vecs[i].csum, vecs[i].seq, 1'b0, "vec");
            chk("vec_sent_count", sent_count, i + 1);
            chk("vec_idle_after", busy, 0);
        end

        // Overflow: sink stalled, four back-to-back pulses.
        mode = 2;
        repeat (3) @(posedge clk);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            settlement_packet = ovf[j];
            packet_valid = 1'b1;
        end
        @(posedge clk); #1;
        packet_valid = 1'b0;
        chk("ovf_fifo_count", fifo_count, 2);
        chk("ovf_drop_count", drop_count, 1);
        chk("ovf_stalled_first", {tx_valid, tx_first}, 2'b11);

        mode = 0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1;
            if (tx_valid && tx_last) break;
        end
        chk("ovf_found_trailer", tx_valid && tx_last, 1);
        settlement_packet = ovf[4];
        packet_valid = 1'b1;
        @(posedge clk); #1;
        packet_valid = 1'b0;
        chk("pushpop_fifo_count", fifo_count, 2);
        chk("pushpop_drop_count", drop_count, 1);

        wait_beats(4 * (NB + 1));
        check_pkt(ovf[0], 32'd1, 16'd4, 1'b0, "ovf_a");
        check_pkt(ovf[1], 32'd2, 16'd5, 1'b1, "ovf_b");
        check_pkt(ovf[2], 32'd3, 16'd6, 1'b1, "ovf_c");
        check_pkt(ovf[4], 32'd5, 16'd7, 1'b1, "ovf_e");
        chk("ovf_sent_count", sent_count, 8);
        chk("ovf_drop_final", drop_count, 1);
        chk("ovf_leftover", q.size(), 0);

        // Reset while beat 10 is on the link.
        send_pkt(pf);
        for (int t = 0; t < 200; t++) begin
            if (q.size() >= 10) break;
            @(posedge clk);
        end
        #1;
        chk("mid_beats_seen", q.size(), 10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_tx_first", tx_first, 0);
        chk("mid_rst_tx_last", tx_last, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_fifo_count", fifo_count, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_drop", drop_count, 0);
        chk("mid_rst_sent", sent_count, 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_pkt(pg);
        wait_beats(NB + 1);
        check_pkt(pg, 32'hA5, 16'd0, 1'b0, "post_rst");
        chk("post_rst_sent", sent_count, 1);
        repeat (3) @(posedge clk);
        chk("post_rst_no_extra", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xras_settlement_serializer.md
Name: xras_settlement_serializer

Overview:
- Downstream of the XRAS top-level settlement stage.
- Captures 4096-bit settlement packets, which arrive as single-cycle valid pulses with no backpressure, into a small packet FIFO.
- Serializes each packet into BEAT_W-wide beats on a valid/ready link toward XRST, then appends one trailer beat carrying an XOR checksum and a sequence number.
- Counts dropped (FIFO overflow) and sent packets for status reporting.

Parameters:
- PKT_W, 4096, settlement packet width; must be a multiple of BEAT_W.
- BEAT_W, 128, output beat width; must be a multiple of 32 and at least 64.
- FIFO_DEPTH, 2, packet FIFO entries; must be at least 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- settlement_packet  input  PKT_W  packet from settlement stage
- packet_valid  input  1  one-cycle strobe; packet is sampled on this edge
- tx_data  output  BEAT_W  beat payload
- tx_valid  output  1  beat valid
- tx_ready  input  1  sink accepts beat when tx_valid && tx_ready
- tx_first  output  1  first data beat of a packet
- tx_last  output  1  trailer beat (last beat of a packet)
- fifo_count  output  $clog2(FIFO_DEPTH+1)  packets queued, excluding the one being sent
- busy  output  1  state != IDLE
- drop_count  output  16  packets lost to overflow; saturates at 0xFFFF
- sent_count  output  16  packets fully sent; wraps

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (rst_n). All flops clear on reset.
- Output reset values:
  - tx_valid=0, tx_first=0, tx_last=0, tx_data=0
  - fifo_count=0, busy=0, drop_count=0, sent_count=0
  - sequence register=0, state=IDLE
- Reset mid-packet: the packet in flight and all FIFO contents are discarded. No trailer is emitted.
- FIFO push: packet_valid pushes the packet when fifo_count<FIFO_DEPTH, or when a pop occurs in the same cycle (full with simultaneous pop is accepted).
- FIFO overflow: when the FIFO is full and no pop occurs, the packet is dropped and drop_count increments, saturating at 0xFFFF.
- Number of data beats: NB = PKT_W/BEAT_W (32 by default).
- Beat order: beat k carries settlement_packet[k*BEAT_W +: BEAT_W], low beat first.
- States:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, clear the checksum, set beat_idx=0, and go to DATA.
  - DATA: tx_valid=1. tx_first=1 only when beat_idx=0. On each handshake:
    - checksum ^= XOR of the BEAT_W/32 words of the beat;
    - beat_idx++;
    - after the handshake on beat NB-1, go to TRAILER.
  - TRAILER: tx_valid=1, tx_last=1.
    - tx_data[31:0] = checksum; tx_data[47:32] = seq; all other bits 0.
    - On handshake: seq++ (wraps), sent_count++ (wraps).
    - Then go to IDLE, or pop the next packet directly and go to DATA if the FIFO is non-empty. There is no idle bubble between packets.
- Latency: a pulse at edge N into an empty FIFO in IDLE gives fifo_count=1 in cycle N+1. The pop happens at edge N+1, so tx_valid=1 with tx_first=1 appears in cycle N+2.
- Backpressure: while tx_valid=1 and tx_ready=0, tx_data, tx_first and tx_last hold stable. tx_valid never drops before its handshake.
- Packet length: exactly NB+1 beats per packet.
- Flag exclusivity: tx_first and tx_last are never high together.
- Output register: tx_data is driven from a register (shift register or trailer), not combinationally from settlement_packet.

Test Plan:
- Single packet: word i = i for i=0..127, tx_ready held 1.
  - tx_valid rises 2 cycles after the pulse; 32 data beats, then the trailer.
  - Beat 0 = {32'd3,32'd2,32'd1,32'd0}.
  - Trailer [31:0] = XOR of 0..127 = 0; seq = 0; sent_count = 1.
- Checksum and sequence: packet with all bits 0 except word 5 = 0xDEADBEEF, sent as the second packet.
  - Trailer[31:0] = 0xDEADBEEF; trailer[47:32] = 1.
- Backpressure: tx_ready toggles 1,0,0,1 repeatedly.
  - Data holds stable while stalled; all 33 beats arrive in order; tx_first only on beat 0; tx_last only on the trailer.
- Overflow, FIFO_DEPTH=2, tx_ready=0: pulse 4 packets on consecutive cycles.
  - First is popped to sending, next 2 queued, 4th dropped.
  - Result: fifo_count=2, drop_count=1. After releasing tx_ready, exactly 3 packets are sent, back-to-back with no idle cycle between trailer and next tx_first.
- Simultaneous push and pop: FIFO full, packet_valid on the same cycle a trailer handshake pops.
  - Packet accepted; drop_count unchanged; fifo_count stays 2.
- Reset mid-operation: assert rst_n=0 during beat 10 of a packet.
  - All outputs return to reset values immediately (asynchronous).
  - After release, a new packet is sent with seq=0 and sent_count goes 0→1.
